// File: rtl/iob_fifo_sync_asym_ctrl.sv
// Single-clock FIFO controller for an external asymmetric-width 2-port RAM.
// Tracks occupancy in minimum-width units and drives the RAM address/enable ports.
module iob_fifo_sync_asym_ctrl #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4,
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
    localparam int MINADDR_W = ADDR_W - $clog2(MAXDATA_W / MINDATA_W),
    localparam int W_ADDR_W  = (W_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W,
    localparam int R_ADDR_W  = (R_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                ext_mem_w_en,
    output logic [W_DATA_W-1:0] ext_mem_w_data,
    output logic [W_ADDR_W-1:0] ext_mem_w_addr,
    output logic                ext_mem_r_en,
    output logic [R_ADDR_W-1:0] ext_mem_r_addr,
    input  logic [R_DATA_W-1:0] ext_mem_r_data
);

    localparam int LVL_W  = ADDR_W + 1;
    localparam int W_INCR = W_DATA_W / MINDATA_W;
    localparam int R_INCR = R_DATA_W / MINDATA_W;

    localparam logic [LVL_W-1:0] W_INCR_L   = LVL_W'(W_INCR);
    localparam logic [LVL_W-1:0] R_INCR_L   = LVL_W'(R_INCR);
    localparam logic [LVL_W-1:0] FULL_THR_L = LVL_W'((1 << ADDR_W) - W_INCR);

    logic [W_ADDR_W-1:0] r_w_ptr;
    logic [R_ADDR_W-1:0] r_r_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [LVL_W-1:0]    w_level_nxt;
    logic                w_flush;
    logic                w_full_int;
    logic                w_empty_int;
    logic                w_wr_ok;
    logic                w_rd_ok;

    assign w_flush     = rst | clr;
    assign w_full_int  = (r_level > FULL_THR_L);
    assign w_empty_int = (r_level < R_INCR_L);

    // A flush cycle accepts nothing, so the RAM is never touched while state clears.
    assign w_wr_ok = w_en & ~w_full_int & ~w_flush;
    assign w_rd_ok = r_en & ~w_empty_int & ~w_flush;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_ok) begin
            w_level_nxt = w_level_nxt + W_INCR_L;
        end
        if (w_rd_ok) begin
            w_level_nxt = w_level_nxt - R_INCR_L;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) begin
                r_w_ptr <= r_w_ptr + W_ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_r_ptr <= r_r_ptr + R_ADDR_W'(1);
            end
            r_level <= w_level_nxt;
        end
    end

    assign w_full         = w_full_int;
    assign r_empty        = w_empty_int;
    assign level          = r_level;
    assign ext_mem_w_en   = w_wr_ok;
    assign ext_mem_w_data = w_data;
    assign ext_mem_w_addr = r_w_ptr;
    assign ext_mem_r_en   = w_rd_ok;
    assign ext_mem_r_addr = r_r_ptr;
    assign r_data         = ext_mem_r_data;

endmodule

// File: tb/tb_iob_fifo_sync_asym_ctrl.sv
// Bench for iob_fifo_sync_asym_ctrl: a 32->8 instance driven from a vector table and a
// streaming model, plus an 8->32 instance driven by a short hand-written sequence.
module tb_iob_fifo_sync_asym_ctrl;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 32-bit write, 8-bit read
    logic        a_rst, a_clr, a_w_en, a_r_en, a_w_full, a_r_empty, a_mwe, a_mre;
    logic [31:0] a_w_data, a_mwd;
    logic [7:0]  a_r_data, a_mrd;
    logic [4:0]  a_level;
    logic [1:0]  a_mwa;
    logic [3:0]  a_mra;

    // Instance B: 8-bit write, 32-bit read
    logic        b_rst, b_clr, b_w_en, b_r_en, b_w_full, b_r_empty, b_mwe, b_mre;
    logic [7:0]  b_w_data, b_mwd;
    logic [31:0] b_r_data, b_mrd;
    logic [4:0]  b_level;
    logic [3:0]  b_mwa;
    logic [1:0]  b_mra;

    iob_fifo_sync_asym_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
        .clk(clk), .rst(a_rst), .clr(a_clr),
        .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
        .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty), .level(a_level),
        .ext_mem_w_en(a_mwe), .ext_mem_w_data(a_mwd), .ext_mem_w_addr(a_mwa),
        .ext_mem_r_en(a_mre), .ext_mem_r_addr(a_mra), .ext_mem_r_data(a_mrd)
    );

    iob_fifo_sync_asym_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr),
        .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
        .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty), .level(b_level),
        .ext_mem_w_en(b_mwe), .ext_mem_w_data(b_mwd), .ext_mem_w_addr(b_mwa),
        .ext_mem_r_en(b_mre), .ext_mem_r_addr(b_mra), .ext_mem_r_data(b_mrd)
    );

    // Byte-addressed RAM models, little-endian slice order, 1-cycle registered read.
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];

    always @(posedge clk) begin
        if (a_mwe) begin
            for (int i = 0; i < 4; i++) mem_a[{a_mwa, 2'(i)}] <= a_mwd[8*i +: 8];
        end
        if (a_mre) a_mrd <= mem_a[a_mra];
        if (b_mwe) mem_b[b_mwa] <= b_mwd;
        if (b_mre) b_mrd <= {mem_b[{b_mra, 2'd3}], mem_b[{b_mra, 2'd2}],
                             mem_b[{b_mra, 2'd1}], mem_b[{b_mra, 2'd0}]};
    end

    typedef struct {
        int          rst, clr, we;
        logic [31:0] wd;
        int          re;
        int          lvl, full, empty, mwe, mre, waddr, raddr;
        int          chk_rd, rd;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int rst, int clr, int we, logic [31:0] wd, int re,
                                int lvl, int full, int empty, int mwe, int mre,
                                int waddr, int raddr, int chk_rd, int rd);
        vec_t v;
        v.rst = rst; v.clr = clr; v.we = we; v.wd = wd; v.re = re;
        v.lvl = lvl; v.full = full; v.empty = empty; v.mwe = mwe; v.mre = mre;
        v.waddr = waddr; v.raddr = raddr; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic b_drive(input logic we, input logic [7:0] wd, input logic re);
        b_w_en   = we;
        b_w_data = wd;
        b_r_en   = re;
        n_vec++;
        #1;
    endtask

    initial begin
        int          mlvl, sent, got, cyc;
        logic [3:0]  mrptr;
        logic [1:0]  mwptr;
        logic [7:0]  q[$];
        logic [7:0]  exp_rd;
        bit          pend, ew, er;
        vec_t        v;

        a_rst = 1'b1; a_clr = 1'b0; a_w_en = 1'b0; a_r_en = 1'b0; a_w_data = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0; b_w_data = '0;
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;

        //             rst clr we wdata          re  lvl fu em mwe mre wa ra  chk rd
        tbl.push_back(mk(0, 0, 1, 32'h44332211, 1,   0, 0, 1, 1, 0,  0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,   4, 0, 0, 0, 1,  1, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,   3, 0, 0, 0, 1,  1, 1,  1, 'h11));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,   2, 0, 0, 0, 1,  1, 2,  1, 'h22));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,   1, 0, 0, 0, 1,  1, 3,  1, 'h33));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,   0, 0, 1, 0, 0,  1, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0,   0, 0, 1, 0, 0,  1, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 1, 32'h03020100, 0,   0, 0, 1, 1, 0,  1, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 1, 32'h07060504, 0,   4, 0, 0, 1, 0,  2, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 1, 32'h0B0A0908, 0,   8, 0, 0, 1, 0,  3, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 1, 32'h0F0E0D0C, 0,  12, 0, 0, 1, 0,  0, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0,  16, 1, 0, 0, 0,  1, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0,  16, 1, 0, 0, 0,  1, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  16, 1, 0, 0, 1,  1, 4,  1, 'h44));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  15, 1, 0, 0, 1,  1, 5,  1, 'h00));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  14, 1, 0, 0, 1,  1, 6,  1, 'h01));
        tbl.push_back(mk(0, 0, 1, 32'h13121110, 1,  13, 1, 0, 0, 1,  1, 7,  1, 'h02));
        tbl.push_back(mk(0, 0, 1, 32'h13121110, 1,  12, 0, 0, 1, 1,  1, 8,  1, 'h03));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0,  15, 1, 0, 0, 0,  2, 9,  1, 'h04));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  15, 1, 0, 0, 1,  2, 9,  1, 'h04));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  14, 1, 0, 0, 1,  2, 10, 1, 'h05));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  13, 1, 0, 0, 1,  2, 11, 1, 'h06));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  12, 0, 0, 0, 1,  2, 12, 1, 'h07));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  11, 0, 0, 0, 1,  2, 13, 1, 'h08));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  10, 0, 0, 0, 1,  2, 14, 1, 'h09));
        tbl.push_back(mk(1, 0, 1, 32'hFFFFFFFF, 0,   9, 0, 0, 0, 0,  2, 15, 1, 'h0A));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0,   0, 0, 1, 0, 0,  0, 0,  1, 'h0A));
        tbl.push_back(mk(0, 0, 1, 32'h33221100, 0,   0, 0, 1, 1, 0,  0, 0,  1, 'h0A));
        tbl.push_back(mk(0, 0, 1, 32'h77665544, 0,   4, 0, 0, 1, 0,  1, 0,  1, 'h0A));
        tbl.push_back(mk(0, 0, 1, 32'hBBAA9988, 0,   8, 0, 0, 1, 0,  2, 0,  1, 'h0A));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  12, 0, 0, 0, 1,  3, 0,  1, 'h0A));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  11, 0, 0, 0, 1,  3, 1,  1, 'h00));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,  10, 0, 0, 0, 1,  3, 2,  1, 'h11));
        tbl.push_back(mk(0, 1, 1, 32'hCAFEF00D, 1,   9, 0, 0, 0, 0,  3, 3,  1, 'h22));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0,   0, 0, 1, 0, 0,  0, 0,  1, 'h22));
        tbl.push_back(mk(0, 0, 1, 32'h04030201, 1,   0, 0, 1, 1, 0,  0, 0,  1, 'h22));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1,   4, 0, 0, 0, 1,  1, 0,  1, 'h22));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0,   3, 0, 0, 0, 0,  1, 1,  1, 'h01));

        for (int k = 0; k < tbl.size(); k++) begin
            v        = tbl[k];
            a_rst    = (v.rst != 0);
            a_clr    = (v.clr != 0);
            a_w_en   = (v.we != 0);
            a_w_data = v.wd;
            a_r_en   = (v.re != 0);
            n_vec++;
            #1;
            chk($sformatf("v%0d level", k),   32'(a_level),   32'(v.lvl));
            chk($sformatf("v%0d w_full", k),  32'(a_w_full),  32'(v.full));
            chk($sformatf("v%0d r_empty", k), 32'(a_r_empty), 32'(v.empty));
            chk($sformatf("v%0d mem_w_en", k), 32'(a_mwe),    32'(v.mwe));
            chk($sformatf("v%0d mem_r_en", k), 32'(a_mre),    32'(v.mre));
            chk($sformatf("v%0d mem_w_addr", k), 32'(a_mwa),  32'(v.waddr));
            chk($sformatf("v%0d mem_r_addr", k), 32'(a_mra),  32'(v.raddr));
            if (v.we != 0) chk($sformatf("v%0d mem_w_data", k), a_mwd, v.wd);
            if (v.chk_rd != 0) chk($sformatf("v%0d r_data", k), 32'(a_r_data), 32'(v.rd));
            @(negedge clk);
        end

        // Streaming wrap-around: 10 words in, 40 bytes out, checked against a byte queue.
        a_rst = 1'b1; a_clr = 1'b0; a_w_en = 1'b0; a_r_en = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;
        mlvl = 0; sent = 0; got = 0; cyc = 0; mrptr = '0; mwptr = '0; pend = 1'b0;
        while ((got < 40 || pend) && cyc < 300) begin
            a_w_en = (sent < 10);
            for (int i = 0; i < 4; i++) a_w_data[8*i +: 8] = 8'(8'h40 + 4 * sent + i);
            a_r_en = (got < 40);
            n_vec++;
            #1;
            if (pend) chk($sformatf("stream byte %0d", got - 1), 32'(a_r_data), 32'(exp_rd));
            ew = a_w_en && (mlvl <= 12);
            er = a_r_en && (mlvl >= 1);
            chk($sformatf("stream c%0d mem_w_en", cyc), 32'(a_mwe), 32'(ew));
            chk($sformatf("stream c%0d mem_r_en", cyc), 32'(a_mre), 32'(er));
            chk($sformatf("stream c%0d mem_w_addr", cyc), 32'(a_mwa), 32'(mwptr));
            chk($sformatf("stream c%0d mem_r_addr", cyc), 32'(a_mra), 32'(mrptr));
            chk($sformatf("stream c%0d level", cyc), 32'(a_level), 32'(mlvl));
            pend = 1'b0;
            if (er) begin
                exp_rd = q.pop_front();
                pend   = 1'b1;
                got++;
                mrptr++;
            end
            if (ew) begin
                for (int i = 0; i < 4; i++) q.push_back(a_w_data[8*i +: 8]);
                sent++;
                mwptr++;
            end
            mlvl = mlvl + (ew ? 4 : 0) - (er ? 1 : 0);
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stream timeout: got %0d bytes, expected 40", got);
        end
        a_w_en = 1'b0;
        a_r_en = 1'b0;
        #1;
        chk("stream final level", 32'(a_level), 32'd0);
        chk("stream final r_empty", 32'(a_r_empty), 32'd1);
        @(negedge clk);

        // 8 -> 32: read stays refused until a whole 32-bit word is present.
        b_drive(1'b1, 8'hAA, 1'b0);
        chk("b0 level", 32'(b_level), 32'd0);
        chk("b0 r_empty", 32'(b_r_empty), 32'd1);
        chk("b0 mem_w_en", 32'(b_mwe), 32'd1);
        @(negedge clk);
        b_drive(1'b1, 8'hBB, 1'b0);
        chk("b1 level", 32'(b_level), 32'd1);
        @(negedge clk);
        b_drive(1'b1, 8'hCC, 1'b1);
        chk("b2 mem_r_en", 32'(b_mre), 32'd0);
        chk("b2 mem_w_addr", 32'(b_mwa), 32'd2);
        @(negedge clk);
        b_drive(1'b0, 8'h00, 1'b1);
        chk("b3 level", 32'(b_level), 32'd3);
        chk("b3 r_empty", 32'(b_r_empty), 32'd1);
        chk("b3 mem_r_en", 32'(b_mre), 32'd0);
        @(negedge clk);
        b_drive(1'b1, 8'hDD, 1'b1);
        chk("b4 mem_r_en", 32'(b_mre), 32'd0);
        chk("b4 mem_w_en", 32'(b_mwe), 32'd1);
        @(negedge clk);
        b_drive(1'b0, 8'h00, 1'b1);
        chk("b5 level", 32'(b_level), 32'd4);
        chk("b5 r_empty", 32'(b_r_empty), 32'd0);
        chk("b5 mem_r_en", 32'(b_mre), 32'd1);
        chk("b5 mem_r_addr", 32'(b_mra), 32'd0);
        @(negedge clk);
        b_drive(1'b0, 8'h00, 1'b0);
        chk("b6 r_data", b_r_data, 32'hDDCCBBAA);
        chk("b6 level", 32'(b_level), 32'd0);
        chk("b6 r_empty", 32'(b_r_empty), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            b_drive(1'b1, 8'(i), 1'b0);
            chk($sformatf("bfill%0d level", i), 32'(b_level), 32'(i));
            chk($sformatf("bfill%0d w_full", i), 32'(b_w_full), 32'(i == 16));
            chk($sformatf("bfill%0d mem_w_en", i), 32'(b_mwe), 32'(i < 16));
            @(negedge clk);
        end
        b_w_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
